mm_burst_arbiter: RTL and testbench
===================================

MM_BURST_ARBITER -- requirements
Module: mm_burst_arbiter

Interface
REQ-001 SHALL have parameter BURST_WIDTH, default 4, giving the words per burst; the value is a power of 2 and at least 2.
REQ-002 SHALL have parameter WORD_SIZE, default 32, giving the data width in bits.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high.
REQ-005 SHALL have ports req0 and req1, input, 1 bit each: burst request from requester 0 (I-side refill) and requester 1 (D-side refill/writeback).
REQ-006 SHALL have ports we0 and we1, input, 1 bit each: burst direction, 1 = write to main memory, 0 = read.
REQ-007 SHALL have ports addr0 and addr1, input, 32 bits each: byte address of the line; the low log2(BURST_WIDTH)+2 bits are ignored.
REQ-008 SHALL have ports wdata0 and wdata1, input, WORD_SIZE bits each: write word for the current beat.
REQ-009 SHALL have ports gnt0 and gnt1, output, 1 bit each: registered grant.
REQ-010 SHALL have ports valid0 and valid1, output, 1 bit each: beat complete for that requester.
REQ-011 SHALL have ports done0 and done1, output, 1 bit each: last beat of the burst.
REQ-012 SHALL have port rdata, output, WORD_SIZE bits: read word, mm_dout passed through.
REQ-013 SHALL have port beat, output, log2(BURST_WIDTH) bits: current word index within the line.
REQ-014 SHALL have port busy, output, 1 bit: high while the arbiter is in state BUSY.
REQ-015 SHALL have ports mm_re and mm_we, output, 1 bit each: main memory read and write enables.
REQ-016 SHALL have port mm_addr, output, 30 bits: main memory word address.
REQ-017 SHALL have port mm_din, output, WORD_SIZE bits: main memory write data.
REQ-018 SHALL have port mm_dout, input, WORD_SIZE bits: main memory read data.
REQ-019 SHALL have port mm_valid, input, 1 bit: main memory beat-complete strobe.

Function
REQ-020 SHALL implement two states, IDLE and BUSY.
REQ-021 In IDLE with any req high, SHALL latch the winner's line address and we, assert its gnt and enter BUSY on the next edge; grant latency is 1 cycle.
REQ-022 In BUSY: mm_re = ~we_latched and mm_we = we_latched; both are 0 in IDLE.
REQ-023 SHALL drive mm_addr = {latched_addr[31:log2(BURST_WIDTH)+2], beat}.
REQ-024 SHALL drive mm_din with the granted requester's wdata.
REQ-025 valid_i = mm_valid & gnt_i; each valid increments beat; beat wraps to 0 after BURST_WIDTH-1.
REQ-026 done_i = valid_i & (beat == BURST_WIDTH-1), combinational; on that edge SHALL return to IDLE and clear gnt.
REQ-027 One IDLE cycle SHALL separate consecutive bursts; req still high after done is a new request.
REQ-028 req deassertion during BUSY SHALL be ignored; the burst always completes.
REQ-029 mm_valid while in IDLE SHALL be ignored.
REQ-030 A requester's we and addr changes after grant SHALL be ignored.
REQ-031 At most one gnt SHALL be high at any time.

Reset
REQ-032 While reset is high, at the edge, SHALL force state IDLE, gnt0/1=0, beat=0 and the priority pointer to favour requester 0.
REQ-033 Reset SHALL abort any burst, including mid-burst: mm_re, mm_we, valid and done are 0 in the following cycle.

Configuration
REQ-034 With MM_ARB_ROUND_ROBIN_EN defined, on simultaneous requests SHALL grant the requester not granted last; the pointer updates at each grant.
REQ-035 Without MM_ARB_ROUND_ROBIN_EN, requester 0 SHALL always win simultaneous requests and no pointer SHALL exist.

Verification
REQ-036 req0=1, we0=0, addr0=0x0000_1234 from idle -> gnt0 high next cycle; mm_addr sequence 0x48C,0x48D,0x48E,0x48F; done0 with the 4th mm_valid; IDLE one cycle later.
REQ-037 req1=1, we1=1, addr1=0x6010, wdata1 indexed by beat -> mm_we=1, mm_din tracks beat 0..3, mm_addr 0x1804..0x1807, done1 on the last beat.
REQ-038 req0 and req1 held high continuously with MM_ARB_ROUND_ROBIN_EN -> grants alternate 0,1,0,1; without the macro -> gnt0 on every burst and gnt1 never.
REQ-039 req0 dropped after beat 1 -> burst still completes 4 beats and done0 asserts.
REQ-040 reset asserted after beat 2 -> next cycle gnt0=0, mm_re=0, beat=0, state IDLE; a subsequent req1 is granted normally.
REQ-041 mm_valid pulsed in IDLE -> no valid, done or beat change.

Source files
------------

// File: rtl/mm_burst_arbiter_if.sv
// Bus bundle for mm_burst_arbiter: two burst requesters on one side and the
// main-memory port on the other. The arbiter connects through the slave
// modport; the requesters plus memory model drive through the master modport.
interface mm_burst_arbiter_if #(
  parameter int BURST_WIDTH = 4,
  parameter int WORD_SIZE   = 32
);
  localparam int BEAT_W = $clog2(BURST_WIDTH);

  // requester side
  logic                 req0;
  logic                 req1;
  logic                 we0;
  logic                 we1;
  logic [31:0]          addr0;
  logic [31:0]          addr1;
  logic [WORD_SIZE-1:0] wdata0;
  logic [WORD_SIZE-1:0] wdata1;
  logic                 gnt0;
  logic                 gnt1;
  logic                 valid0;
  logic                 valid1;
  logic                 done0;
  logic                 done1;
  logic [WORD_SIZE-1:0] rdata;
  logic [BEAT_W-1:0]    beat;
  logic                 busy;

  // main-memory side
  logic                 mm_re;
  logic                 mm_we;
  logic [29:0]          mm_addr;
  logic [WORD_SIZE-1:0] mm_din;
  logic [WORD_SIZE-1:0] mm_dout;
  logic                 mm_valid;

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    output mm_dout, mm_valid,
    input  gnt0, gnt1, valid0, valid1, done0, done1, rdata, beat, busy,
    input  mm_re, mm_we, mm_addr, mm_din
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    input  mm_dout, mm_valid,
    output gnt0, gnt1, valid0, valid1, done0, done1, rdata, beat, busy,
    output mm_re, mm_we, mm_addr, mm_din
  );
endinterface

// File: rtl/mm_burst_arbiter.sv
// mm_burst_arbiter: grants one of two requesters a full BURST_WIDTH-word
// burst to main memory, sequencing the word index and returning to IDLE on
// the last beat. Build option: define MM_ARB_ROUND_ROBIN_EN to alternate
// grants on simultaneous requests; otherwise requester 0 has fixed priority.
module mm_burst_arbiter #(
  parameter int BURST_WIDTH = 4,
  parameter int WORD_SIZE   = 32
) (
  input logic               clk,
  input logic               reset,
  mm_burst_arbiter_if.slave bus
);
  localparam int BEAT_W = $clog2(BURST_WIDTH);
  localparam int LINE_W = 30 - BEAT_W;

  typedef enum logic { IDLE = 1'b0, BUSY = 1'b1 } state_t;

  state_t              state_q, state_d;
  logic                gnt0_q, gnt0_d;
  logic                gnt1_q, gnt1_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic                load;
  logic                pick1;
  logic                last_beat;
  logic                valid0, valid1;
  logic [LINE_W-1:0]   line_q;
  logic                we_q;
  logic [WORD_SIZE-1:0] din_sel;
  logic                unused_addr_bits;

`ifdef MM_ARB_ROUND_ROBIN_EN
  // 1 = requester 1 wins the next tie
  logic prio_q, prio_d;
`else
`endif

  // Low address bits select bytes/words inside the line and are not stored.
  assign unused_addr_bits = ^{bus.addr0[BEAT_W+1:0], bus.addr1[BEAT_W+1:0]};

  assign last_beat = (beat_q == BEAT_W'(BURST_WIDTH - 1));
  // gnt is only ever high in BUSY, so mm_valid in IDLE cannot leak through.
  assign valid0    = bus.mm_valid & gnt0_q;
  assign valid1    = bus.mm_valid & gnt1_q;
  assign din_sel   = gnt1_q ? bus.wdata1 : bus.wdata0;

  assign bus.gnt0    = gnt0_q;
  assign bus.gnt1    = gnt1_q;
  assign bus.valid0  = valid0;
  assign bus.valid1  = valid1;
  assign bus.done0   = valid0 & last_beat;
  assign bus.done1   = valid1 & last_beat;
  assign bus.rdata   = bus.mm_dout;
  assign bus.beat    = beat_q;
  assign bus.busy    = (state_q == BUSY);
  assign bus.mm_re   = (state_q == BUSY) & ~we_q;
  assign bus.mm_we   = (state_q == BUSY) & we_q;
  assign bus.mm_addr = {line_q, beat_q};
  assign bus.mm_din  = din_sel;

  // Next-state logic: pick a winner in IDLE, count beats in BUSY.
  always_comb begin
    state_d = state_q;
    gnt0_d  = gnt0_q;
    gnt1_d  = gnt1_q;
    beat_d  = beat_q;
    load    = 1'b0;
`ifdef MM_ARB_ROUND_ROBIN_EN
    prio_d  = prio_q;
    pick1   = bus.req1 & (~bus.req0 | prio_q);
`else
    pick1   = bus.req1 & ~bus.req0;
`endif
    case (state_q)
      IDLE: begin
        if (bus.req0 | bus.req1) begin
          load    = 1'b1;
          gnt0_d  = ~pick1;
          gnt1_d  = pick1;
          state_d = BUSY;
`ifdef MM_ARB_ROUND_ROBIN_EN
          prio_d  = ~pick1;
`else
`endif
        end
      end
      BUSY: begin
        if (valid0 | valid1) begin
          beat_d = beat_q + BEAT_W'(1);
          if (last_beat) begin
            state_d = IDLE;
            gnt0_d  = 1'b0;
            gnt1_d  = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers; reset aborts any burst in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      beat_q  <= '0;
`ifdef MM_ARB_ROUND_ROBIN_EN
      prio_q  <= 1'b0;
`else
`endif
    end else begin
      state_q <= state_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      beat_q  <= beat_d;
`ifdef MM_ARB_ROUND_ROBIN_EN
      prio_q  <= prio_d;
`else
`endif
    end
  end

  // Capture the winner's line address and direction at grant time only.
  always_ff @(posedge clk) begin
    if (load) begin
      line_q <= pick1 ? bus.addr1[31:BEAT_W+2] : bus.addr0[31:BEAT_W+2];
      we_q   <= pick1 ? bus.we1 : bus.we0;
    end
  end
endmodule

// File: tb/tb_mm_burst_arbiter.sv
// Directed testbench for mm_burst_arbiter (BURST_WIDTH=4, WORD_SIZE=32).
module tb_mm_burst_arbiter;
  logic clk;
  logic reset;
  int   checks;
  int   failures;

  mm_burst_arbiter_if #(.BURST_WIDTH(4), .WORD_SIZE(32)) bus ();

  mm_burst_arbiter #(.BURST_WIDTH(4), .WORD_SIZE(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One accepted beat: raise mm_valid, check strobes and address, then clock.
  task automatic run_beat(input string tag, input logic [29:0] ea,
                          input logic v0, input logic v1,
                          input logic d0, input logic d1);
    logic [31:0] rd;
    rd = $urandom;
    bus.mm_valid = 1'b1;
    bus.mm_dout  = rd;
    settle();
    check({tag, "_addr"},   {2'b00, bus.mm_addr}, {2'b00, ea});
    check({tag, "_valid0"}, {31'd0, bus.valid0}, {31'd0, v0});
    check({tag, "_valid1"}, {31'd0, bus.valid1}, {31'd0, v1});
    check({tag, "_done0"},  {31'd0, bus.done0},  {31'd0, d0});
    check({tag, "_done1"},  {31'd0, bus.done1},  {31'd0, d1});
    check({tag, "_rdata"},  bus.rdata, rd);
    check({tag, "_onegnt"}, {31'd0, bus.gnt0 & bus.gnt1}, 32'd0);
    tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.we0  = 1'b0; bus.we1  = 1'b0;
    bus.addr0 = '0;  bus.addr1 = '0;
    bus.wdata0 = '0; bus.wdata1 = '0;
    bus.mm_dout = '0; bus.mm_valid = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    settle();
    check("rst_gnt0",  {31'd0, bus.gnt0},  32'd0);
    check("rst_gnt1",  {31'd0, bus.gnt1},  32'd0);
    check("rst_busy",  {31'd0, bus.busy},  32'd0);
    check("rst_beat",  {30'd0, bus.beat},  32'd0);
    check("rst_mm_re", {31'd0, bus.mm_re}, 32'd0);
    check("rst_mm_we", {31'd0, bus.mm_we}, 32'd0);

    // Read burst from requester 0, with one stall cycle mid-burst
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 32'h0000_1234;
    tick();
    bus.req0 = 1'b0;
    settle();
    check("rd_gnt0",  {31'd0, bus.gnt0},  32'd1);
    check("rd_gnt1",  {31'd0, bus.gnt1},  32'd0);
    check("rd_busy",  {31'd0, bus.busy},  32'd1);
    check("rd_mm_re", {31'd0, bus.mm_re}, 32'd1);
    check("rd_mm_we", {31'd0, bus.mm_we}, 32'd0);
    run_beat("rd_b0", 30'h48C, 1'b1, 1'b0, 1'b0, 1'b0);
    run_beat("rd_b1", 30'h48D, 1'b1, 1'b0, 1'b0, 1'b0);
    bus.mm_valid = 1'b0;
    settle();
    check("rd_stall_valid0", {31'd0, bus.valid0}, 32'd0);
    tick();
    check("rd_stall_beat", {30'd0, bus.beat}, 32'd2);
    run_beat("rd_b2", 30'h48E, 1'b1, 1'b0, 1'b0, 1'b0);
    run_beat("rd_b3", 30'h48F, 1'b1, 1'b0, 1'b1, 1'b0);
    bus.mm_valid = 1'b0;
    settle();
    check("rd_end_busy",  {31'd0, bus.busy},  32'd0);
    check("rd_end_gnt0",  {31'd0, bus.gnt0},  32'd0);
    check("rd_end_mm_re", {31'd0, bus.mm_re}, 32'd0);
    check("rd_end_beat",  {30'd0, bus.beat},  32'd0);

    // mm_valid pulsed while idle has no effect
    bus.mm_valid = 1'b1;
    settle();
    check("idle_valid0", {31'd0, bus.valid0}, 32'd0);
    check("idle_valid1", {31'd0, bus.valid1}, 32'd0);
    check("idle_done0",  {31'd0, bus.done0},  32'd0);
    tick();
    bus.mm_valid = 1'b0;
    settle();
    check("idle_beat", {30'd0, bus.beat}, 32'd0);
    check("idle_busy", {31'd0, bus.busy}, 32'd0);

    // Write burst from requester 1; we/addr changes after grant are ignored
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 32'h0000_6010;
    tick();
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = 32'hFFFF_FFF0;
    settle();
    check("wr_gnt1",  {31'd0, bus.gnt1},  32'd1);
    check("wr_gnt0",  {31'd0, bus.gnt0},  32'd0);
    check("wr_mm_re", {31'd0, bus.mm_re}, 32'd0);
    for (int b = 0; b < 4; b++) begin
      bus.wdata1 = 32'hD0 + b;
      bus.wdata0 = 32'h5555_0000 + b;
      settle();
      check("wr_mm_din", bus.mm_din, 32'hD0 + b);
      check("wr_mm_we",  {31'd0, bus.mm_we}, 32'd1);
      run_beat("wr", 30'h1804 + 30'(b), 1'b0, 1'b1, 1'b0, (b == 3));
    end
    bus.mm_valid = 1'b0;
    settle();
    check("wr_end_busy", {31'd0, bus.busy}, 32'd0);
    check("wr_end_gnt1", {31'd0, bus.gnt1}, 32'd0);

    // req0 dropped after beat 1; burst still completes
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 32'h0000_0100;
    tick();
    settle();
    check("drop_gnt0", {31'd0, bus.gnt0}, 32'd1);
    for (int b = 0; b < 4; b++) begin
      if (b == 2) bus.req0 = 1'b0;
      run_beat("drop", 30'h40 + 30'(b), 1'b1, 1'b0, (b == 3), 1'b0);
    end
    bus.mm_valid = 1'b0;
    settle();
    check("drop_end_busy", {31'd0, bus.busy}, 32'd0);
    tick();
    check("drop_no_regrant", {31'd0, bus.busy}, 32'd0);

    // Reset mid-burst, then a fresh request from requester 1
    bus.req0 = 1'b1; bus.addr0 = 32'h0000_0200;
    tick();
    bus.req0 = 1'b0;
    settle();
    check("abort_gnt0", {31'd0, bus.gnt0}, 32'd1);
    run_beat("abort_b0", 30'h80, 1'b1, 1'b0, 1'b0, 1'b0);
    run_beat("abort_b1", 30'h81, 1'b1, 1'b0, 1'b0, 1'b0);
    check("abort_beat2", {30'd0, bus.beat}, 32'd2);
    reset = 1'b1;
    bus.mm_valid = 1'b0;
    tick();
    reset = 1'b0;
    bus.mm_valid = 1'b1;
    settle();
    check("abort_gnt0_clr", {31'd0, bus.gnt0},   32'd0);
    check("abort_mm_re",    {31'd0, bus.mm_re},  32'd0);
    check("abort_beat",     {30'd0, bus.beat},   32'd0);
    check("abort_busy",     {31'd0, bus.busy},   32'd0);
    check("abort_valid0",   {31'd0, bus.valid0}, 32'd0);
    check("abort_done0",    {31'd0, bus.done0},  32'd0);
    bus.mm_valid = 1'b0;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 32'h0000_0040;
    tick();
    bus.req1 = 1'b0;
    settle();
    check("post_gnt1",  {31'd0, bus.gnt1},  32'd1);
    check("post_mm_re", {31'd0, bus.mm_re}, 32'd1);
    for (int b = 0; b < 4; b++)
      run_beat("post", 30'h10 + 30'(b), 1'b0, 1'b1, 1'b0, (b == 3));
    bus.mm_valid = 1'b0;

    // Both requesters held high across four bursts
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    bus.we0 = 1'b0;  bus.we1 = 1'b0;
    bus.addr0 = 32'h0000_0000; bus.addr1 = 32'h0000_1000;
    for (int k = 0; k < 4; k++) begin
      logic exp1;
`ifdef MM_ARB_ROUND_ROBIN_EN
      exp1 = (k % 2) == 1;
`else
      exp1 = 1'b0;
`endif
      tick();
      settle();
      check("both_gnt0", {31'd0, bus.gnt0}, {31'd0, ~exp1});
      check("both_gnt1", {31'd0, bus.gnt1}, {31'd0, exp1});
      for (int b = 0; b < 4; b++)
        run_beat("both", (exp1 ? 30'h400 : 30'h0) + 30'(b),
                 ~exp1, exp1, ~exp1 & (b == 3), exp1 & (b == 3));
      bus.mm_valid = 1'b0;
      settle();
      check("both_gap_busy", {31'd0, bus.busy}, 32'd0);
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
